// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg
// Shared types, response codes and the burst address sequencer for the
// debug-link AXI4 responder. No ports; imported by the responder files.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address of the beat following 'addr'. Works on a 64-bit address so any
  // ADDR_WIDTH up to 64 can use it; callers truncate the result.
  // Reserved bursts step like INCR (those beats are errored anyway).
  function automatic logic [63:0] axi_next_addr(
    input logic [63:0] addr,
    input logic [2:0]  size,
    input logic [7:0]  len,
    input logic [1:0]  burst
  );
    logic [63:0] step;
    logic [63:0] win_mask;
    logic [63:0] nxt;
    step     = 64'd1 << size;
    // Wrap window is (len+1) beats of (1<<size) bytes, aligned to its size.
    win_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~win_mask) | ((addr + step) & win_mask);
      default:     nxt = addr + step;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_burst_responder_if.sv
// axi_burst_responder_if
// AXI4 bus bundle between the debug-link master and the burst responder.
// Channels: AW (address + sideband), W (data/strobe/last), B (response),
// AR (address + sideband), R (data/resp/last/id).
// Modports: slave (responder side), master (requester / bench side).
interface axi_burst_responder_if #(
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  import axi_burst_pkg::*;

  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [ID_WIDTH-1:0]     awid;
  logic [2:0]              awprot;
  logic                    awlock;
  logic [3:0]              awcache, awqos, awregion;

  logic                    wvalid, wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid, bready;
  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;

  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [ID_WIDTH-1:0]     arid;
  logic [2:0]              arprot;
  logic                    arlock;
  logic [3:0]              arcache, arqos, arregion;

  logic                    rvalid, rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [ID_WIDTH-1:0]     rid;

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid, awprot, awlock, awcache, awqos, awregion,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid, arprot, arlock, arcache, arqos, arregion,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid, awprot, awlock, awcache, awqos, awregion,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid, arprot, arlock, arcache, arqos, arregion,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

endinterface

// File: rtl/axi_bram_be.sv
// axi_bram_be
// Single-port synchronous RAM with per-byte write enables, written as a plain
// array so it maps onto block RAM. Contents are not reset.
// Ports: i_clk; i_re read enable (o_rdata updates the next edge, holds
// otherwise); i_we per-byte write enables; i_addr word index; i_wdata;
// o_rdata registered read data.
module axi_bram_be #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 2048
) (
  input  logic                         i_clk,
  input  logic                         i_re,
  input  logic [DATA_WIDTH/8-1:0]      i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-enabled write and enable-gated registered read.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_burst_responder.sv
// axi_burst_responder
// AXI4 slave for the debug link: services one FIXED/INCR/WRAP burst at a time
// from an internal byte-enabled RAM, with per-beat SLVERR responses.
// Ports: clk (rising edge), rst (synchronous, active-high), s_axi (slave
// modport carrying the AW/W/B/AR/R channels). All outputs are registered.
module axi_burst_responder
  import axi_burst_pkg::*;
#(
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 2048
) (
  input  logic clk,
  input  logic rst,
  axi_burst_responder_if.slave s_axi
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam logic [2:0] ADDR_LSB_3 = 3'(ADDR_LSB);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

  logic [1:0]            r_state;
  logic                  r_last_was_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_cfg_err, r_wr_err, r_issue_done;
  logic                  r_awready, r_arready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  // Read pipeline: p1 = beat whose data sits in the RAM output register.
  logic                  r_p1_valid, r_p1_err, r_p1_last;
  logic                  r_rvalid, r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic                  w_grant_aw, w_grant_ar;
  logic                  w_out_free, w_p1_free, w_issue, w_last_beat, w_beat_err;
  logic [ADDR_WIDTH-1:0] w_next_addr, w_req_addr;
  logic [7:0]            w_req_len;
  logic [2:0]            w_req_size;
  logic [1:0]            w_req_burst;
  logic [ID_WIDTH-1:0]   w_req_id;
  logic                  w_req_cfg_err;
  logic [STRB_W-1:0]     w_we;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_unused_sidebands;

  assign w_unused_sidebands = ^{s_axi.awprot, s_axi.awlock, s_axi.awcache, s_axi.awqos,
                                s_axi.awregion, s_axi.arprot, s_axi.arlock, s_axi.arcache,
                                s_axi.arqos, s_axi.arregion};

  // Handshakes, arbitration, read-pipeline flow control and beat status.
  always_comb begin
    w_aw_hs     = s_axi.awvalid & r_awready;
    w_ar_hs     = s_axi.arvalid & r_arready;
    w_w_hs      = s_axi.wvalid & r_wready;
    w_b_hs      = r_bvalid & s_axi.bready;
    w_r_hs      = r_rvalid & s_axi.rready;
    // Ties go to the channel that did not win last time.
    w_grant_aw  = s_axi.awvalid & (~s_axi.arvalid | ~r_last_was_write);
    w_grant_ar  = s_axi.arvalid & (~s_axi.awvalid | r_last_was_write);
    w_out_free  = ~r_rvalid | s_axi.rready;
    w_p1_free   = ~r_p1_valid | w_out_free;
    // A new RAM read is issued only if the RAM output register can be
    // overwritten, so a stalled beat is never lost.
    w_issue     = (r_state == ST_RDATA) & ~r_issue_done & w_p1_free;
    w_last_beat = (r_cnt == r_len);
    w_beat_err  = r_cfg_err | (r_addr >= MEM_BYTES);
    w_next_addr = ADDR_WIDTH'(axi_next_addr(64'(r_addr), r_size, r_len, r_burst));
  end

  // Select the request fields of whichever address channel is being accepted.
  always_comb begin
    if (r_awready) begin
      w_req_addr  = s_axi.awaddr;
      w_req_len   = s_axi.awlen;
      w_req_size  = s_axi.awsize;
      w_req_burst = s_axi.awburst;
      w_req_id    = s_axi.awid;
    end else begin
      w_req_addr  = s_axi.araddr;
      w_req_len   = s_axi.arlen;
      w_req_size  = s_axi.arsize;
      w_req_burst = s_axi.arburst;
      w_req_id    = s_axi.arid;
    end
    w_req_cfg_err = (w_req_size > ADDR_LSB_3) | (w_req_burst == BURST_RSVD) |
                    ((w_req_burst == BURST_WRAP) &
                     ~((w_req_len == 8'd1) | (w_req_len == 8'd3) |
                       (w_req_len == 8'd7) | (w_req_len == 8'd15)));
  end

  // Errored write beats leave the RAM untouched.
  always_comb begin
    if (w_w_hs && !w_beat_err) begin
      w_we = s_axi.wstrb;
    end else begin
      w_we = {STRB_W{1'b0}};
    end
  end

  axi_bram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .i_clk   (clk),
    .i_re    (w_issue),
    .i_we    (w_we),
    .i_addr  (r_addr[ADDR_LSB +: IDX_W]),
    .i_wdata (s_axi.wdata),
    .o_rdata (w_ram_rdata)
  );

  // Burst control FSM: address acceptance, write beats, write response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_last_was_write <= 1'b0;
      r_addr           <= {ADDR_WIDTH{1'b0}};
      r_len            <= 8'd0;
      r_cnt            <= 8'd0;
      r_size           <= 3'd0;
      r_burst          <= 2'd0;
      r_id             <= {ID_WIDTH{1'b0}};
      r_cfg_err        <= 1'b0;
      r_wr_err         <= 1'b0;
      r_issue_done     <= 1'b0;
      r_awready        <= 1'b0;
      r_arready        <= 1'b0;
      r_wready         <= 1'b0;
      r_bvalid         <= 1'b0;
      r_bresp          <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs || w_ar_hs) begin
            r_addr           <= w_req_addr;
            r_len            <= w_req_len;
            r_size           <= w_req_size;
            r_burst          <= w_req_burst;
            r_id             <= w_req_id;
            r_cfg_err        <= w_req_cfg_err;
            r_cnt            <= 8'd0;
            r_wr_err         <= 1'b0;
            r_issue_done     <= 1'b0;
            r_awready        <= 1'b0;
            r_arready        <= 1'b0;
            r_last_was_write <= w_aw_hs;
            r_wready         <= w_aw_hs;
            r_state          <= w_aw_hs ? ST_WDATA : ST_RDATA;
          end else begin
            r_awready <= w_grant_aw;
            r_arready <= w_grant_ar;
          end
        end
        ST_WDATA: begin
          if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
            // The beat count ends the burst; a misplaced wlast only errors it.
            if (w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_wr_err | w_beat_err | ~s_axi.wlast) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= ST_WRESP;
            end else begin
              r_wr_err <= r_wr_err | w_beat_err | s_axi.wlast;
            end
          end
        end
        ST_WRESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= w_grant_aw;
            r_arready <= w_grant_ar;
            r_state   <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          if (w_issue) begin
            r_addr       <= w_next_addr;
            r_cnt        <= r_cnt + 8'd1;
            r_issue_done <= w_last_beat;
          end
          if (w_r_hs && r_rlast) begin
            r_awready <= w_grant_aw;
            r_arready <= w_grant_ar;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read pipeline: RAM output stage (p1) feeding the held R output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_valid <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p1_last  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= {DATA_WIDTH{1'b0}};
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_p1_valid <= 1'b1;
        r_p1_err   <= w_beat_err;
        r_p1_last  <= w_last_beat;
      end else if (w_out_free) begin
        r_p1_valid <= 1'b0;
      end
      if (w_out_free) begin
        r_rvalid <= r_p1_valid;
        if (r_p1_valid) begin
          r_rdata <= r_p1_err ? {DATA_WIDTH{1'b0}} : w_ram_rdata;
          r_rresp <= r_p1_err ? RESP_SLVERR : RESP_OKAY;
          r_rlast <= r_p1_last;
        end
      end
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.arready = r_arready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.bid     = r_id;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rid     = r_id;

endmodule

// File: doc/axi_burst_responder.md
# axi_burst_responder

AXI4 slave (responder) end of the debug AXI link: accepts read and write bursts from the JTAG-driven AXI master and services them from an internal byte-enabled synchronous RAM. Supports FIXED, INCR and WRAP bursts, narrow transfers and per-beat error responses. It sits where the AXI memory model sits today, as the synthesizable target of the master's `M_AXI_*` port set.

## Interface
- `ID_WIDTH`, 10, AXI ID width for AW/AR/R/B.
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 64, data width. Power of two, 32..128.
- `MEM_WORDS`, 2048, RAM depth in `DATA_WIDTH` words (16 KiB at 64 bits).
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `S_AXI_aw*` (awvalid, awready out, awaddr, awlen 8, awsize 3, awburst 2, awid, awprot/awlock/awcache/awqos/awregion): write address channel. Prot, lock, cache, qos and region are accepted and ignored.
- `S_AXI_w*` (wvalid, wready out, wdata, wstrb `DATA_WIDTH/8`, wlast): write data channel.
- `S_AXI_b*` (bvalid out, bready, bresp 2 out, bid out): write response channel.
- `S_AXI_ar*`: read address channel. Same fields as AW; arready is an output.
- `S_AXI_r*` (rvalid out, rready, rdata out, rresp 2 out, rlast out, rid out): read data channel.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE: `awready`/`arready` reflect the grant.
  - If only one of `awvalid`/`arvalid` is high, that channel is granted.
  - If both are high, round-robin using the `last_was_write` flag. The flag resets to 0, so writes win the first tie.
- On the AW handshake, latch addr, len, size, burst and id, then go to WDATA.
- On the AR handshake, latch the same fields, then go to RDATA.
- Address sequencing after each beat:
  - FIXED (00): address is unchanged.
  - INCR (01): `addr + (1<<size)`.
  - WRAP (10): increment within the aligned `(len+1)<<size` window, wrapping to the window base.
  - Reserved (11): sequenced as INCR; every beat responds SLVERR.
- RAM word index is `addr[ADDR_LSB +: log2(MEM_WORDS)]`, where `ADDR_LSB = log2(DATA_WIDTH/8)`.
- A beat gets SLVERR (10) when any of these holds:
  - `size > ADDR_LSB`;
  - burst is 11;
  - `addr >= MEM_WORDS*DATA_WIDTH/8`;
  - WRAP with len not in {1,3,7,15}.
- Errored write beats do not touch RAM. Errored read beats return `rdata = 0`.
- WDATA: `wready` is high. Each handshake writes the bytes enabled by `wstrb`. Beat count (len+1) ends the burst.
  - `wlast` present on any beat other than the final one, or absent on the final one, sets the burst error flag. The count still governs.
- WRESP: `bresp` is SLVERR if any beat errored, else OKAY. `bid = awid`. Hold `bvalid` until `bready`, then go to IDLE.
- RDATA: len+1 beats. `rid = arid`, `rlast` on beat len, per-beat `rresp`. After the `rlast` handshake, go to IDLE.
- Only one burst is in flight at a time. No outstanding-transaction queue.

## Timing
- Reset values: every valid/ready output is 0; `bresp`, `rresp`, `rdata`, `rid`, `bid` and `rlast` are 0; FSM is IDLE; counters and error flag are cleared. RAM contents are not reset.
- `awready`/`arready` are high only in IDLE and are registered. The earliest they can rise is the cycle after reset deasserts.
- Write: the RAM write occurs on the w handshake edge. `bvalid` rises the cycle after the final w handshake.
- Read: RAM latency is 1 cycle. The first `rvalid` is 2 cycles after the AR handshake.
- With `rready` held high, read throughput is 1 beat/cycle with no bubbles.
- While `rvalid && !rready`, `rdata`, `rresp` and `rlast` are held stable. The RAM enable is gated (or a one-entry skid register is used) so no beat is lost.
- Return to IDLE: IDLE is entered on the cycle after the final B or R handshake. The next AW/AR can be accepted on that cycle.
- `rst` during a burst: all channels drop on the next edge and FSM returns to IDLE. No further beats or responses are issued for the aborted burst. Partially written RAM data remains.

## Structure
- Package `axi_burst_pkg`:
  - burst-type enum (FIXED/INCR/WRAP/RSVD);
  - response constants OKAY = 00, SLVERR = 10;
  - pure function `axi_next_addr(addr, size, len, burst)`.
- Sub-module `axi_bram_be`: single-port synchronous RAM, `MEM_WORDS` deep, with per-byte write enables and a read enable. Plain `always_ff` array so it infers block RAM.

## Test plan
- Single write then read: AW addr 0x80, len 0, size 3, `wstrb` 0xFF, data 0x0123456789ABCDEF → B OKAY with bid echoed. AR of the same address → `rdata` 0x0123456789ABCDEF, `rlast` = 1, OKAY, `rvalid` 2 cycles after the AR handshake.
- INCR write: 4 beats from 0x100 with data 1..4, then a FIXED read of len 3 at 0x108 → four beats of value 2, `rlast` only on the 4th.
- WRAP read: len 3, size 3, start 0x118, memory word k = k → addresses 0x118, 0x100, 0x108, 0x110 → data 0x23, 0x20, 0x21, 0x22.
- Narrow and strobe: write size 2 at 0x204 with `wstrb` 0xF0 and data 0xAAAAAAAA_00000000 → read of 0x200 shows only the upper 4 bytes changed.
- Errors and backpressure:
  - write to 0x4000 → SLVERR, RAM unchanged;
  - read with size 4 → SLVERR on every beat, `rdata` 0;
  - read with `rready` toggling 1,0,0,1 → beats stable, none dropped or duplicated.
- Arbitration and reset:
  - `awvalid` and `arvalid` asserted together twice → write first, then read;
  - `rst` asserted for 1 cycle mid 8-beat read → no further `rvalid`, IDLE on the next cycle, a fresh AR is accepted.
